// File: rtl/hyperbus_responder_if.sv
// HyperBus pad-side signal bundle between an initiator and the responder model.
// master: initiator side (drives CK, CS#, RESET#, DQ/RWDS inputs to the responder)
// slave : responder side (drives DQ/RWDS outputs and their enables)
interface hyperbus_responder_if;
  localparam int unsigned DQ_W = 8;

  logic            dram_ck;
  logic            dram_cs_l;
  logic            dram_rst_l;
  logic [DQ_W-1:0] dq_in;
  logic [DQ_W-1:0] dq_out;
  logic            dq_oe;
  logic            rwds_in;
  logic            rwds_out;
  logic            rwds_oe;

  modport master (
    output dram_ck, dram_cs_l, dram_rst_l, dq_in, rwds_in,
    input  dq_out, dq_oe, rwds_out, rwds_oe
  );

  modport slave (
    input  dram_ck, dram_cs_l, dram_rst_l, dq_in, rwds_in,
    output dq_out, dq_oe, rwds_out, rwds_oe
  );
endinterface

// File: rtl/hyperbus_responder.sv
// HyperRAM-style responder: decodes a 48-bit command/address, waits a fixed
// latency, then streams 16-bit words from/to a small internal memory or CR0.
// Ports:
//   hram_clk   - system clock, all logic on its rising edge
//   reset      - synchronous active-high reset
//   bus        - HyperBus pad signals (slave modport)
//   txn_count  - completed transaction counter, wraps
//   err_pulse  - one-cycle pulse when CS# rises before the CA phase completes
module hyperbus_responder #(
  parameter int unsigned ADDR_BITS = 8,
  parameter int unsigned LAT_EDGES = 22,
  parameter logic [15:0] CR0_INIT  = 16'h8F1F
) (
  input  logic                 hram_clk,
  input  logic                 reset,
  hyperbus_responder_if.slave  bus,
  output logic [15:0]          txn_count,
  output logic                 err_pulse
);
  localparam int unsigned DEPTH = 1 << ADDR_BITS;
  localparam int unsigned LAT_W = $clog2(LAT_EDGES + 2);
  localparam int unsigned CA_W  = 48;

  typedef enum logic [2:0] {IDLE, CA, LAT, RDATA, WDATA, REGW} state_t;

  // Pad sampling stage; ck_q2 holds the previous sampled CK for edge detect.
  logic       ck_q, ck_q2, cs_l_q, rst_l_q, rwds_q;
  logic [7:0] dq_q;

  always_ff @(posedge hram_clk) begin
    ck_q    <= bus.dram_ck;
    ck_q2   <= ck_q;
    cs_l_q  <= bus.dram_cs_l;
    rst_l_q <= bus.dram_rst_l;
    dq_q    <= bus.dq_in;
    rwds_q  <= bus.rwds_in;
  end

  logic ck_edge;
  assign ck_edge = ck_q ^ ck_q2;

  state_t               state;
  logic [2:0]           byte_cnt;
  logic [39:0]          ca_sr;
  logic [ADDR_BITS-1:0] addr;
  logic                 lane_lo;
  logic                 is_read;
  logic                 is_reg;
  logic [LAT_W-1:0]     lat_cnt;
  logic [1:0]           reg_cnt;
  logic [7:0]           reg_hi;
  logic [15:0]          cr0;
  logic [7:0]           dq_out_r;
  logic                 dq_oe_r, rwds_out_r, rwds_oe_r;

  logic [15:0]          mem [DEPTH];
  logic [15:0]          rd_word;
  logic [CA_W-1:0]      ca_next;
  logic                 mem_we_hi, mem_we_lo;

  assign ca_next = {ca_sr, dq_q};
  assign rd_word = is_reg ? cr0 : mem[addr];

  // CA[45] and CA[15:3] carry no meaning for this device.
  logic unused_ca;
  assign unused_ca = ^{ca_next[45], ca_next[15:3]};

  // Byte-lane write strobes; RWDS high masks the lane.
  always_comb begin
    mem_we_hi = 1'b0;
    mem_we_lo = 1'b0;
    if (!reset && rst_l_q && !cs_l_q && state == WDATA && ck_edge && !rwds_q) begin
      if (lane_lo) mem_we_lo = 1'b1;
      else         mem_we_hi = 1'b1;
    end
  end

  // Storage array, intentionally not reset.
  always_ff @(posedge hram_clk) begin
    if (mem_we_hi) mem[addr][15:8] <= dq_q;
    if (mem_we_lo) mem[addr][7:0]  <= dq_q;
  end

  // Transaction counter: only the system reset clears it.
  always_ff @(posedge hram_clk) begin
    if (reset)
      txn_count <= '0;
    else if (rst_l_q && cs_l_q && state != IDLE && state != CA)
      txn_count <= txn_count + 16'd1;
  end

  // Main protocol state machine with registered pad outputs.
  always_ff @(posedge hram_clk) begin
    if (reset || !rst_l_q) begin
      state      <= IDLE;
      byte_cnt   <= '0;
      ca_sr      <= '0;
      addr       <= '0;
      lane_lo    <= 1'b0;
      is_read    <= 1'b0;
      is_reg     <= 1'b0;
      lat_cnt    <= '0;
      reg_cnt    <= '0;
      reg_hi     <= '0;
      cr0        <= CR0_INIT;
      dq_out_r   <= '0;
      dq_oe_r    <= 1'b0;
      rwds_out_r <= 1'b0;
      rwds_oe_r  <= 1'b0;
      err_pulse  <= 1'b0;
    end else begin
      err_pulse <= 1'b0;
      if (state != IDLE && cs_l_q) begin
        // CS# released: abandon whatever phase we were in and free the pads.
        state      <= IDLE;
        dq_out_r   <= '0;
        dq_oe_r    <= 1'b0;
        rwds_out_r <= 1'b0;
        rwds_oe_r  <= 1'b0;
        err_pulse  <= (state == CA);
      end else begin
        case (state)
          IDLE: begin
            // An edge coinciding with CS# fall is not a CA byte.
            if (!cs_l_q) begin
              state      <= CA;
              byte_cnt   <= '0;
              rwds_oe_r  <= 1'b1;
              rwds_out_r <= 1'b1;
            end
          end
          CA: begin
            if (ck_edge) begin
              ca_sr    <= ca_next[39:0];
              byte_cnt <= byte_cnt + 3'd1;
              if (byte_cnt == 3'd5) begin
                is_read    <= ca_next[47];
                is_reg     <= ca_next[46];
                addr       <= ADDR_BITS'({ca_next[44:16], ca_next[2:0]});
                lane_lo    <= 1'b0;
                reg_cnt    <= '0;
                lat_cnt    <= LAT_W'(LAT_EDGES);
                rwds_oe_r  <= 1'b0;
                rwds_out_r <= 1'b0;
                if (!ca_next[47] && ca_next[46])
                  state <= REGW;
                else if (LAT_EDGES == 0)
                  state <= ca_next[47] ? RDATA : WDATA;
                else
                  state <= LAT;
              end
            end
          end
          LAT: begin
            if (ck_edge) begin
              lat_cnt <= lat_cnt - LAT_W'(1);
              if (lat_cnt == LAT_W'(1))
                state <= is_read ? RDATA : WDATA;
            end
          end
          RDATA: begin
            // Upper byte first; RWDS marks the upper byte high.
            if (ck_edge) begin
              dq_oe_r    <= 1'b1;
              rwds_oe_r  <= 1'b1;
              rwds_out_r <= !lane_lo;
              dq_out_r   <= lane_lo ? rd_word[7:0] : rd_word[15:8];
              lane_lo    <= !lane_lo;
              if (lane_lo) addr <= addr + ADDR_BITS'(1);
            end
          end
          WDATA: begin
            if (ck_edge) begin
              lane_lo <= !lane_lo;
              if (lane_lo) addr <= addr + ADDR_BITS'(1);
            end
          end
          REGW: begin
            // CR0 is loaded as a whole word once both bytes have arrived.
            if (ck_edge) begin
              if (reg_cnt == 2'd0) begin
                reg_hi  <= dq_q;
                reg_cnt <= 2'd1;
              end else if (reg_cnt == 2'd1) begin
                cr0     <= {reg_hi, dq_q};
                reg_cnt <= 2'd2;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.dq_out   = dq_out_r;
  assign bus.dq_oe    = dq_oe_r;
  assign bus.rwds_out = rwds_out_r;
  assign bus.rwds_oe  = rwds_oe_r;
endmodule

// File: tb/tb_hyperbus_responder.sv
// Self-checking bench for hyperbus_responder: directed table, corner sequences,
// then randomized transactions against a word/byte-level memory model.
module tb_hyperbus_responder;
  localparam int unsigned ADDR_BITS = 8;
  localparam int unsigned LAT_EDGES = 22;
  localparam int unsigned DEPTH     = 1 << ADDR_BITS;
  localparam int unsigned NBUF      = 512;

  logic        hram_clk = 1'b0;
  logic        reset;
  logic [15:0] txn_count;
  logic        err_pulse;

  hyperbus_responder_if bus();

  hyperbus_responder #(
    .ADDR_BITS(ADDR_BITS),
    .LAT_EDGES(LAT_EDGES),
    .CR0_INIT (16'h8F1F)
  ) dut (
    .hram_clk (hram_clk),
    .reset    (reset),
    .bus      (bus),
    .txn_count(txn_count),
    .err_pulse(err_pulse)
  );

  always #5 hram_clk = ~hram_clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Reference state
  logic [15:0] mem_m [DEPTH];
  logic [15:0] cr0_m;
  int unsigned txn_m;

  // Per-transaction stimulus / expectation buffers
  logic [7:0] wbuf   [NBUF];
  logic       wmask  [NBUF];
  logic [7:0] exp_rd [NBUF];

  typedef struct {
    logic [47:0] ca;
    int unsigned n;
    logic [31:0] wdata;   // byte k at [31-8k -: 8]
    logic [3:0]  wmask;   // byte k masked when bit [3-k] set
    logic [31:0] exp;     // read bytes, same packing as wdata
  } vec_t;

  vec_t tbl [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge hram_clk);
    #1;
  endtask

  task automatic ck_edge(input logic [7:0] d, input logic r);
    bus.dq_in   = d;
    bus.rwds_in = r;
    bus.dram_ck = ~bus.dram_ck;
    tick();
    tick();
  endtask

  function automatic int unsigned word_addr(input logic [47:0] ca, input int unsigned k);
    int unsigned base;
    base = 32'({ca[44:16], ca[2:0]});
    return (base + k / 2) % DEPTH;
  endfunction

  function automatic void model_expect(input logic [47:0] ca, input int unsigned n);
    logic [15:0] v;
    for (int unsigned k = 0; k < n; k++) begin
      v = ca[46] ? cr0_m : mem_m[word_addr(ca, k)];
      exp_rd[k] = (k % 2 == 0) ? v[15:8] : v[7:0];
    end
  endfunction

  function automatic void model_write(input logic [47:0] ca, input int unsigned n);
    int unsigned w;
    if (ca[46]) begin
      if (n >= 2) cr0_m = {wbuf[0], wbuf[1]};
    end else begin
      for (int unsigned k = 0; k < n; k++) begin
        w = word_addr(ca, k);
        if (!wmask[k]) begin
          if (k % 2 == 0) mem_m[w][15:8] = wbuf[k];
          else            mem_m[w][7:0]  = wbuf[k];
        end
      end
    end
  endfunction

  // One CS# window: ca_bytes < 6 aborts inside the CA phase.
  task automatic do_txn(input logic [47:0] ca, input int unsigned nbytes,
                        input int unsigned ca_bytes, input bit pre_edge);
    logic [47:0] sh;
    bit          rd, zero_lat;
    rd       = ca[47];
    zero_lat = !ca[47] && ca[46];
    bus.dram_cs_l = 1'b0;
    if (pre_edge) begin
      bus.dq_in   = 8'h00;
      bus.dram_ck = ~bus.dram_ck;
    end
    tick();
    tick();
    for (int unsigned i = 0; i < ca_bytes; i++) begin
      sh = ca << (8 * i);
      ck_edge(sh[47:40], 1'b0);
      if (i == 0) begin
        check("ca_rwds_oe", 32'(bus.rwds_oe), 32'(1));
        check("ca_rwds_out", 32'(bus.rwds_out), 32'(1));
      end
      if (i == 5) check("post_ca_rwds_oe", 32'(bus.rwds_oe), 32'(0));
    end
    if (ca_bytes == 6) begin
      if (!zero_lat)
        for (int unsigned i = 0; i < LAT_EDGES; i++) ck_edge(8'($urandom), 1'($urandom));
      for (int unsigned k = 0; k < nbytes; k++) begin
        if (rd) begin
          ck_edge(8'($urandom), 1'($urandom));
          check("rd_dq_oe", 32'(bus.dq_oe), 32'(1));
          check("rd_dq_out", 32'(bus.dq_out), 32'(exp_rd[k]));
          check("rd_rwds_oe", 32'(bus.rwds_oe), 32'(1));
          check("rd_rwds_out", 32'(bus.rwds_out), (k % 2 == 0) ? 32'(1) : 32'(0));
        end else begin
          ck_edge(wbuf[k], wmask[k]);
        end
      end
      txn_m++;
    end
    bus.dram_cs_l = 1'b1;
    tick();
    tick();
    check("end_err_pulse", 32'(err_pulse), (ca_bytes < 6) ? 32'(1) : 32'(0));
    check("end_dq_oe", 32'(bus.dq_oe), 32'(0));
    check("end_rwds_oe", 32'(bus.rwds_oe), 32'(0));
    check("txn_count", 32'(txn_count), 32'(16'(txn_m)));
    tick();
    check("err_pulse_width", 32'(err_pulse), 32'(0));
  endtask

  logic [47:0] ca;
  int unsigned n, kind;
  logic [31:0] sh32;
  logic [3:0]  msk;

  initial begin
    tbl[0] = '{48'hE0_00_00_00_00_00, 4, 32'h0,        4'b0000, 32'h8F1F8F1F};
    tbl[1] = '{48'h00_00_00_00_00_04, 4, 32'hDEADBEEF, 4'b0000, 32'h0};
    tbl[2] = '{48'h80_00_00_00_00_04, 4, 32'h0,        4'b0000, 32'hDEADBEEF};
    tbl[3] = '{48'h00_00_00_00_00_04, 2, 32'h11220000, 4'b0100, 32'h0};
    tbl[4] = '{48'h80_00_00_00_00_04, 2, 32'h0,        4'b0000, 32'h11AD0000};
    tbl[5] = '{48'h00_00_00_1F_00_07, 4, 32'h12345678, 4'b0000, 32'h0};
    tbl[6] = '{48'h80_00_00_1F_00_07, 4, 32'h0,        4'b0000, 32'h12345678};
    tbl[7] = '{48'h60_00_00_00_00_00, 2, 32'h8F170000, 4'b0000, 32'h0};
    tbl[8] = '{48'hE0_00_00_00_00_00, 2, 32'h0,        4'b0000, 32'h8F170000};

    reset          = 1'b1;
    bus.dram_ck    = 1'b0;
    bus.dram_cs_l  = 1'b1;
    bus.dram_rst_l = 1'b1;
    bus.dq_in      = 8'h00;
    bus.rwds_in    = 1'b0;
    txn_m          = 0;
    cr0_m          = 16'h8F1F;
    repeat (4) tick();
    reset = 1'b0;
    tick();
    check("rst_dq_oe", 32'(bus.dq_oe), 32'(0));
    check("rst_rwds_oe", 32'(bus.rwds_oe), 32'(0));
    check("rst_dq_out", 32'(bus.dq_out), 32'(0));
    check("rst_rwds_out", 32'(bus.rwds_out), 32'(0));
    check("rst_err", 32'(err_pulse), 32'(0));
    check("rst_txn", 32'(txn_count), 32'(0));

    // Directed table
    for (int i = 0; i < 9; i++) begin
      for (int unsigned k = 0; k < 4; k++) begin
        sh32      = tbl[i].wdata << (8 * k);
        wbuf[k]   = sh32[31:24];
        sh32      = tbl[i].exp << (8 * k);
        exp_rd[k] = sh32[31:24];
        msk       = tbl[i].wmask << k;
        wmask[k]  = msk[3];
      end
      do_txn(tbl[i].ca, tbl[i].n, 6, 1'b0);
    end
    cr0_m = 16'h8F17;

    // Abort after three CA bytes
    do_txn(48'h80_00_00_00_00_04, 0, 3, 1'b0);

    // Device reset with CS# idle restores CR0 and keeps the counter
    bus.dram_rst_l = 1'b0;
    tick();
    tick();
    bus.dram_rst_l = 1'b1;
    tick();
    tick();
    check("rst_l_txn_kept", 32'(txn_count), 32'(16'(txn_m)));
    cr0_m = 16'h8F1F;
    model_expect(48'hE0_00_00_00_00_00, 2);
    do_txn(48'hE0_00_00_00_00_00, 2, 6, 1'b0);

    // CK edge together with CS# fall must not be taken as a CA byte
    model_expect(48'hE0_00_00_00_00_00, 4);
    do_txn(48'hE0_00_00_00_00_00, 4, 6, 1'b1);

    // Device reset mid-latency aborts silently
    bus.dram_cs_l = 1'b0;
    tick();
    tick();
    for (int unsigned i = 0; i < 6; i++) ck_edge((i == 0) ? 8'h80 : 8'h00, 1'b0);
    for (int unsigned i = 0; i < 5; i++) ck_edge(8'h00, 1'b0);
    bus.dram_rst_l = 1'b0;
    tick();
    tick();
    check("midrst_rwds_oe", 32'(bus.rwds_oe), 32'(0));
    bus.dram_cs_l = 1'b1;
    tick();
    tick();
    check("midrst_err", 32'(err_pulse), 32'(0));
    bus.dram_rst_l = 1'b1;
    tick();
    tick();
    check("midrst_err2", 32'(err_pulse), 32'(0));
    check("midrst_txn", 32'(txn_count), 32'(16'(txn_m)));

    // Fill the whole memory so the model is fully known
    for (int unsigned k = 0; k < NBUF; k++) begin
      wbuf[k]  = 8'($urandom);
      wmask[k] = 1'b0;
    end
    do_txn(48'h0, NBUF, 6, 1'b0);
    model_write(48'h0, NBUF);

    // Randomized transactions
    for (int t = 0; t < 120; t++) begin
      kind = $urandom_range(0, 9);
      ca   = {16'($urandom), $urandom};
      n    = $urandom_range(1, 8);
      for (int unsigned k = 0; k < 8; k++) begin
        wbuf[k]  = 8'($urandom);
        wmask[k] = ($urandom_range(0, 3) == 0);
      end
      if (kind == 0) begin
        do_txn(ca, 0, $urandom_range(1, 5), 1'b0);
      end else if (kind == 1) begin
        ca[47:46] = 2'b01;
        n = $urandom_range(2, 6);
        do_txn(ca, n, 6, 1'b0);
        model_write(ca, n);
      end else if (kind == 2) begin
        ca[47:46] = 2'b11;
        model_expect(ca, n);
        do_txn(ca, n, 6, 1'b0);
      end else if (kind <= 6) begin
        ca[47:46] = 2'b00;
        do_txn(ca, n, 6, 1'b0);
        model_write(ca, n);
      end else begin
        ca[47:46] = 2'b10;
        model_expect(ca, n);
        do_txn(ca, n, 6, 1'b0);
      end
    end

    // Read back the entire memory
    model_expect(48'h80_00_00_00_00_00, NBUF);
    do_txn(48'h80_00_00_00_00_00, NBUF, 6, 1'b0);

    // System reset clears the counter
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("final_txn_clear", 32'(txn_count), 32'(0));
    check("final_dq_oe", 32'(bus.dq_oe), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
